sdram_xfer_sched: RTL and testbench
===================================

# sdram_xfer_sched

Transfer scheduler between the UDP command decoder and the SDRAM channel multiplexer. It queues 32-bit command words received over UDP and launches them one at a time. For each command it drives the SDRAM read/write channel selects, the SDRAM bank index and the SD-card BMP read address. It then holds them until the matching read/write completion arrives, so back-to-back UDP commands never overwrite a transfer in flight.

## Interface
Parameters:
- FIFO_DEPTH, 4: command queue depth; power of two, 2..16.
- TIMEOUT_CYC, 24'd12_500_000: WAIT-state cycle limit, used only when XFER_TIMEOUT_EN is defined.

Ports:
- Clock and reset: one clock, `udp_rx_clk`. Reset is `reset`, **synchronous, active-high**.
- udp_rx_clk  in  1  single clock for all logic.
- reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command word present.
- cmd_word  in  32  [3:0] move_type, [5:4] sdram_index, [15:6] sd_card_index, [31:16] reserved.
- cmd_ready  out  1  queue can accept a word.
- read_finish  in  1  read-channel completion level, from another domain.
- write_finish  in  1  write-channel completion level, from another domain.
- read_ch  out  2  read port select.
- write_ch  out  2  write port select.
- sdram_index  out  2  SDRAM bank index of the active transfer.
- sd_card_bmp_read_addr  out  32  SD-card sector address.
- xfer_start  out  1  one-cycle launch strobe.
- xfer_done  out  1  one-cycle completion strobe.
- xfer_err  out  1  one-cycle strobe for a rejected command or a timeout.
- busy  out  1  high when the state machine is not in IDLE.

## Operation
- Queue push: a word is pushed when cmd_valid && cmd_ready, where cmd_ready = !full. Push and pop in the same cycle are legal.
- Move-type decode:
  - 1 (camera→sdram): write_ch=1, read_ch=0; expects write_finish.
  - 2 (sdcard→sdram): write_ch=2, read_ch=0; expects write_finish.
  - 3 (sdram→hdmi): read_ch=1, write_ch=0; expects read_finish.
  - 0: discarded silently.
  - 4..15: rejected.
  - Type 2 with sd_card_index==0: rejected.
- Address: sd_card_bmp_read_addr = (sd_card_index−1)·1800 + 8484, computed in 32 bits unsigned. Valid only for type 2; for any other type the output is 0.
- Finish synchronisers: read_finish and write_finish each pass through a 2-flop synchroniser. Completion is the rising edge of the synchronised signal.
- State machine:
  - IDLE: if the queue is not empty, pop the head into the command register and go to CHECK.
  - CHECK: type 0 → IDLE. Illegal type → xfer_err pulse, then IDLE. Valid type → LAUNCH.
  - LAUNCH: register the channel, index and address outputs; pulse xfer_start; go to WAIT.
  - WAIT: hold all outputs. On a rising edge of the expected finish → DONE. An edge of the other finish is ignored.
  - DONE: pulse xfer_done; clear read_ch, write_ch and the address to 0; go to IDLE.
- Output hold: outputs change only in LAUNCH and DONE.
- Reset values: read_ch=0, write_ch=0, sdram_index=0, address=0, all strobes 0, busy=0, cmd_ready=1. Queue empty, synchronisers cleared.
- Reset mid-transfer: the state machine returns to IDLE and the queue is flushed. No xfer_done or xfer_err is emitted.

## Timing
- Command path: a word pushed at cycle N into an empty queue with the machine in IDLE gives:
  - N+1: pop.
  - N+2: CHECK.
  - N+3: LAUNCH; outputs and xfer_start are visible from N+4.
- Completion path: finish rises at cycle M (raw input):
  - M+2: synchronised edge detected.
  - M+3: DONE, with xfer_done visible at M+3.
  - M+4: IDLE.
- Minimum spacing between xfer_start strobes: 5 cycles.
- Finish edge during CHECK or LAUNCH: not captured; only edges seen in WAIT count.
- Full queue: cmd_ready drops the cycle after the FIFO_DEPTH-th push and reasserts the cycle after a pop.

## Configuration
- XFER_TIMEOUT_EN defined: a 24-bit counter runs in WAIT. At TIMEOUT_CYC it pulses xfer_err and goes to DONE without pulsing xfer_done; outputs are cleared as in a normal DONE.
- XFER_TIMEOUT_EN not defined: the counter and parameter are unused, and WAIT waits indefinitely.

## Structure
- Package sdram_sched_pkg holds:
  - move-type constants MT_NONE, MT_CAM2SDR, MT_SD2SDR, MT_SDR2HDMI;
  - BMP_SECTORS=1800 and BMP_BASE=8484;
  - state encoding S_IDLE, S_CHECK, S_LAUNCH, S_WAIT, S_DONE.
- Sub-module sched_cmd_fifo: synchronous 32-bit FIFO with full and empty flags.

## Test plan
- Push 0x0000_0081 (type 1, idx 0, card 2) → xfer_start after 4 cycles; write_ch=1, read_ch=0, addr=0. Raise write_finish → xfer_done 3 cycles later; write_ch returns to 0.
- Push type 2, card 3 (0x0000_00C2) → addr=12084, write_ch=2. Raising read_finish alone does not complete it; write_finish does.
- Push four words, then a fifth, with FIFO_DEPTH=4 and the first transfer stalled → cmd_ready=0 until the first pop. All accepted commands launch in order.
- Push type 7, then type 2 with card 0 → two xfer_err pulses, no xfer_start; busy returns to 0.
- Assert reset during WAIT with two commands queued → all outputs return to reset values and no launch follows. A new command then runs normally.
- With XFER_TIMEOUT_EN and TIMEOUT_CYC=100, never raise finish → xfer_err 100 cycles after entering WAIT, no xfer_done, channels cleared.

Source files
------------

// File: rtl/sdram_sched_pkg.sv
// Shared definitions for the SDRAM transfer scheduler.
// Holds the move-type codes carried in cmd_word[3:0], the BMP sector layout
// constants used to derive the SD-card read address, and the scheduler
// state encoding.
package sdram_sched_pkg;

  localparam logic [3:0] MT_NONE     = 4'd0;
  localparam logic [3:0] MT_CAM2SDR  = 4'd1;
  localparam logic [3:0] MT_SD2SDR   = 4'd2;
  localparam logic [3:0] MT_SDR2HDMI = 4'd3;

  localparam logic [31:0] BMP_SECTORS = 32'd1800;
  localparam logic [31:0] BMP_BASE    = 32'd8484;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } sched_state_e;

  // Card indices are 1-based; the caller guarantees card != 0.
  function automatic logic [31:0] bmp_read_addr(input logic [9:0] card);
    return ({22'd0, card} - 32'd1) * BMP_SECTORS + BMP_BASE;
  endfunction

endpackage

// File: rtl/sched_cmd_fifo.sv
// Synchronous show-ahead command FIFO for the transfer scheduler.
// Ports:
//   udp_rx_clk, reset : clock and synchronous active-high reset
//   push, wdata       : write request (ignored while full) and data
//   pop               : read request (ignored while empty)
//   rdata             : head entry, valid whenever !empty
//   full, empty       : occupancy flags, registered
module sched_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             udp_rx_clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge udp_rx_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW + 1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge udp_rx_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sdram_xfer_sched.sv
// Transfer scheduler between the UDP command decoder and the SDRAM channel
// multiplexer. Queues 32-bit command words and launches one transfer at a
// time, holding the channel selects, bank index and SD-card address until
// the matching (synchronised) finish edge arrives.
// Ports:
//   udp_rx_clk, reset          : clock, synchronous active-high reset
//   cmd_valid, cmd_word        : command input; cmd_ready = queue not full
//   read_finish, write_finish  : completion levels from another clock domain
//   read_ch, write_ch          : channel selects of the active transfer
//   sdram_index                : SDRAM bank of the active transfer
//   sd_card_bmp_read_addr      : SD-card sector address (type 2 only)
//   xfer_start/done/err        : one-cycle strobes
//   busy                       : state machine not idle
// Optional feature: define XFER_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYC cycles in WAIT (xfer_err instead of xfer_done).
module sdram_xfer_sched
  import sdram_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [23:0] TIMEOUT_CYC = 24'd12_500_000
) (
  input  logic        udp_rx_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_word,
  output logic        cmd_ready,
  input  logic        read_finish,
  input  logic        write_finish,
  output logic [1:0]  read_ch,
  output logic [1:0]  write_ch,
  output logic [1:0]  sdram_index,
  output logic [31:0] sd_card_bmp_read_addr,
  output logic        xfer_start,
  output logic        xfer_done,
  output logic        xfer_err,
  output logic        busy
);

  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic [31:0]  fifo_head;
  sched_state_e state_q;
  logic [15:0]  cmd_q;
  logic         expect_wr_q;
  logic [1:0]   rd_sync_q;
  logic [1:0]   wr_sync_q;
  logic         rd_prev_q;
  logic         wr_prev_q;
  logic         finish_rise;
  logic [3:0]   cmd_type;
  logic [9:0]   cmd_card;
  logic         cmd_legal;
  logic         unused_head_hi;

  assign cmd_ready      = !fifo_full;
  assign fifo_pop       = (state_q == S_IDLE) && !fifo_empty;
  assign busy           = (state_q != S_IDLE);
  assign unused_head_hi = ^fifo_head[31:16];

  assign cmd_type  = cmd_q[3:0];
  assign cmd_card  = cmd_q[15:6];
  assign cmd_legal = (cmd_type == MT_CAM2SDR) || (cmd_type == MT_SDR2HDMI) ||
                     ((cmd_type == MT_SD2SDR) && (cmd_card != 10'd0));

  // Only the finish belonging to the launched transfer can complete it.
  assign finish_rise = expect_wr_q ? (wr_sync_q[1] && !wr_prev_q)
                                   : (rd_sync_q[1] && !rd_prev_q);

  sched_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_cmd_fifo (
    .udp_rx_clk (udp_rx_clk),
    .reset      (reset),
    .push       (cmd_valid),
    .wdata      (cmd_word),
    .pop        (fifo_pop),
    .rdata      (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge udp_rx_clk) begin
    if (reset) begin
      rd_sync_q <= '0;
      wr_sync_q <= '0;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      rd_sync_q <= {rd_sync_q[0], read_finish};
      wr_sync_q <= {wr_sync_q[0], write_finish};
      rd_prev_q <= rd_sync_q[1];
      wr_prev_q <= wr_sync_q[1];
    end
  end

`ifdef XFER_TIMEOUT_EN
  logic [23:0] tmo_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge udp_rx_clk) begin
    if (reset) begin
      state_q               <= S_IDLE;
      cmd_q                 <= '0;
      expect_wr_q           <= 1'b0;
      read_ch               <= 2'd0;
      write_ch              <= 2'd0;
      sdram_index           <= 2'd0;
      sd_card_bmp_read_addr <= 32'd0;
      xfer_start            <= 1'b0;
      xfer_done             <= 1'b0;
      xfer_err              <= 1'b0;
`ifdef XFER_TIMEOUT_EN
      tmo_cnt_q             <= '0;
`endif
    end else begin
      xfer_start <= 1'b0;
      xfer_done  <= 1'b0;
      xfer_err   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            cmd_q   <= fifo_head[15:0];
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (cmd_type == MT_NONE) begin
            state_q <= S_IDLE;
          end else if (cmd_legal) begin
            state_q <= S_LAUNCH;
          end else begin
            xfer_err <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          sdram_index <= cmd_q[5:4];
          case (cmd_type)
            MT_CAM2SDR: begin
              write_ch              <= 2'd1;
              read_ch               <= 2'd0;
              expect_wr_q           <= 1'b1;
              sd_card_bmp_read_addr <= 32'd0;
            end
            MT_SD2SDR: begin
              write_ch              <= 2'd2;
              read_ch               <= 2'd0;
              expect_wr_q           <= 1'b1;
              sd_card_bmp_read_addr <= bmp_read_addr(cmd_card);
            end
            default: begin
              write_ch              <= 2'd0;
              read_ch               <= 2'd1;
              expect_wr_q           <= 1'b0;
              sd_card_bmp_read_addr <= 32'd0;
            end
          endcase
          xfer_start <= 1'b1;
`ifdef XFER_TIMEOUT_EN
          tmo_cnt_q  <= '0;
`endif
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // The done strobe is raised on entry so it coincides with DONE.
          if (finish_rise) begin
            xfer_done <= 1'b1;
            state_q   <= S_DONE;
          end
`ifdef XFER_TIMEOUT_EN
          else if (tmo_cnt_q == TIMEOUT_CYC - 24'd1) begin
            xfer_err <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 24'd1;
          end
`endif
        end
        S_DONE: begin
          read_ch               <= 2'd0;
          write_ch              <= 2'd0;
          sd_card_bmp_read_addr <= 32'd0;
          state_q               <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_xfer_sched.sv
module tb_sdram_xfer_sched;

  logic        udp_rx_clk;
  logic        reset;
  logic        cmd_valid;
  logic [31:0] cmd_word;
  logic        cmd_ready;
  logic        read_finish;
  logic        write_finish;
  logic [1:0]  read_ch;
  logic [1:0]  write_ch;
  logic [1:0]  sdram_index;
  logic [31:0] sd_card_bmp_read_addr;
  logic        xfer_start;
  logic        xfer_done;
  logic        xfer_err;
  logic        busy;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  wch;
    logic [1:0]  rch;
    logic [1:0]  idx;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int n_start      = 0;
  int n_done       = 0;
  int n_err        = 0;
  int last_start   = 0;
  int last_done    = 0;
  int last_err     = 0;
  int t_push       = 0;

  sdram_xfer_sched #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (24'd100)
  ) dut (
    .udp_rx_clk            (udp_rx_clk),
    .reset                 (reset),
    .cmd_valid             (cmd_valid),
    .cmd_word              (cmd_word),
    .cmd_ready             (cmd_ready),
    .read_finish           (read_finish),
    .write_finish          (write_finish),
    .read_ch               (read_ch),
    .write_ch              (write_ch),
    .sdram_index           (sdram_index),
    .sd_card_bmp_read_addr (sd_card_bmp_read_addr),
    .xfer_start            (xfer_start),
    .xfer_done             (xfer_done),
    .xfer_err              (xfer_err),
    .busy                  (busy)
  );

  initial udp_rx_clk = 1'b0;
  always #5 udp_rx_clk = ~udp_rx_clk;

  // Reference decode: which words launch and with what outputs.
  function automatic bit model(input logic [31:0] w, output exp_t e);
    int card;
    card   = int'(w[15:6]);
    e.word = w;
    e.idx  = w[5:4];
    e.wch  = 2'd0;
    e.rch  = 2'd0;
    e.addr = 32'd0;
    case (w[3:0])
      4'd1: begin e.wch = 2'd1; return 1'b1; end
      4'd2: begin
        if (card == 0) return 1'b0;
        e.wch  = 2'd2;
        e.addr = 32'(card * 1800 + 6684);
        return 1'b1;
      end
      4'd3: begin e.rch = 2'd1; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  // One clock; samples strobes and scores every launch against the queue.
  task automatic step();
    exp_t e;
    @(posedge udp_rx_clk);
    #1;
    cyc++;
    if (xfer_start === 1'b1) begin
      n_start++;
      last_start = cyc;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL launch_unexpected: got start wr=%0d rd=%0d idx=%0d, required no launch",
                 write_ch, read_ch, sdram_index);
      end else begin
        e = exp_q.pop_front();
        if ({write_ch, read_ch, sdram_index, sd_card_bmp_read_addr} !==
            {e.wch, e.rch, e.idx, e.addr}) begin
          tests_failed++;
          $display("FAIL launch_fields word=%h: got wr=%0d rd=%0d idx=%0d addr=%0d, required wr=%0d rd=%0d idx=%0d addr=%0d",
                   e.word, write_ch, read_ch, sdram_index, sd_card_bmp_read_addr,
                   e.wch, e.rch, e.idx, e.addr);
        end
      end
    end
    if (xfer_done === 1'b1) begin n_done++; last_done = cyc; end
    if (xfer_err === 1'b1)  begin n_err++;  last_err  = cyc; end
  endtask

  task automatic push_cmd(input logic [31:0] w, input bit will_run);
    exp_t e;
    int   budget;
    budget    = 50;
    cmd_valid = 1'b1;
    cmd_word  = w;
    while (cmd_ready !== 1'b1 && budget > 0) begin step(); budget--; end
    if (cmd_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL push_ready word=%h: got cmd_ready=%b, required 1", w, cmd_ready);
    end
    step();
    t_push    = cyc;
    cmd_valid = 1'b0;
    if (will_run && model(w, e)) exp_q.push_back(e);
  endtask

  task automatic wait_start(input int target, input string name);
    int budget;
    budget = 40;
    while (n_start < target && budget > 0) begin step(); budget--; end
    tests_run++;
    if (n_start < target) begin
      tests_failed++;
      $display("FAIL %s_start: got %0d starts, required %0d", name, n_start, target);
    end
  endtask

  task automatic finish_xfer(input bit is_write, input string name);
    int target;
    int budget;
    int t_f;
    target = n_done + 1;
    budget = 12;
    if (is_write) write_finish = 1'b1;
    else          read_finish  = 1'b1;
    t_f = cyc;
    while (n_done < target && budget > 0) begin step(); budget--; end
    tests_run++;
    if (n_done < target || last_done - t_f != 3) begin
      tests_failed++;
      $display("FAIL %s_done: got done count %0d latency %0d, required count %0d latency 3",
               name, n_done, last_done - t_f, target);
    end
    write_finish = 1'b0;
    read_finish  = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    tests_run++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
    tests_run++;
    if ({read_ch, write_ch, sdram_index} !== 6'd0 || sd_card_bmp_read_addr !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rd=%0d wr=%0d idx=%0d addr=%0d, required all 0",
               read_ch, write_ch, sdram_index, sd_card_bmp_read_addr);
    end
    tests_run++;
    if ({xfer_start, xfer_done, xfer_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_strobes: got %b, required 000", {xfer_start, xfer_done, xfer_err});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_cam2sdr();
    int s0;
    s0 = n_start;
    push_cmd(32'h0000_0081, 1'b1);
    wait_start(s0 + 1, "cam");
    tests_run++;
    if (last_start - t_push != 3) begin
      tests_failed++;
      $display("FAIL cam_latency: got %0d cycles push-to-start, required 3", last_start - t_push);
    end
    repeat (4) step();
    tests_run++;
    if (write_ch !== 2'd1 || read_ch !== 2'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL cam_hold: got wr=%0d rd=%0d busy=%b, required 1 0 1", write_ch, read_ch, busy);
    end
    write_finish = 1'b1;
    finish_xfer(1'b1, "cam");
    tests_run++;
    if (write_ch !== 2'd0 || read_ch !== 2'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL cam_clear: got wr=%0d rd=%0d busy=%b, required 0 0 0", write_ch, read_ch, busy);
    end
  endtask

  task automatic test_sd2sdr();
    int s0;
    int d0;
    s0 = n_start;
    push_cmd(32'h0000_00C2, 1'b1);
    wait_start(s0 + 1, "sd");
    d0 = n_done;
    read_finish = 1'b1;
    repeat (8) step();
    tests_run++;
    if (n_done != d0 || busy !== 1'b1 || sd_card_bmp_read_addr !== 32'd12084) begin
      tests_failed++;
      $display("FAIL sd_wrong_finish: got dones=%0d busy=%b addr=%0d, required dones=%0d busy=1 addr=12084",
               n_done, busy, sd_card_bmp_read_addr, d0);
    end
    read_finish = 1'b0;
    finish_xfer(1'b1, "sd");
    tests_run++;
    if (sd_card_bmp_read_addr !== 32'd0 || write_ch !== 2'd0) begin
      tests_failed++;
      $display("FAIL sd_clear: got addr=%0d wr=%0d, required 0 0", sd_card_bmp_read_addr, write_ch);
    end
  endtask

  task automatic test_full_queue();
    logic [31:0] words [4];
    bit          is_wr [4];
    exp_t        e;
    int          s0;
    int          budget;
    words[0] = 32'h0000_0013; is_wr[0] = 1'b0;
    words[1] = 32'h0000_0161; is_wr[1] = 1'b1;
    words[2] = 32'h0000_01F2; is_wr[2] = 1'b1;
    words[3] = 32'h0000_0003; is_wr[3] = 1'b0;
    s0 = n_start;
    push_cmd(32'h0000_0081, 1'b1);
    wait_start(s0 + 1, "full_first");
    for (int i = 0; i < 4; i++) push_cmd(words[i], 1'b1);
    tests_run++;
    if (cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_ready_drop: got cmd_ready=%b, required 0", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_word  = 32'h0000_0AB2;
    repeat (5) step();
    tests_run++;
    if (cmd_ready !== 1'b0 || n_start != s0 + 1) begin
      tests_failed++;
      $display("FAIL full_stall: got cmd_ready=%b starts=%0d, required 0 %0d",
               cmd_ready, n_start, s0 + 1);
    end
    write_finish = 1'b1;
    budget = 20;
    while (cmd_ready !== 1'b1 && budget > 0) begin step(); budget--; end
    tests_run++;
    if (cmd_ready !== 1'b1 || n_start != s0 + 1) begin
      tests_failed++;
      $display("FAIL full_ready_back: got cmd_ready=%b starts=%0d, required 1 %0d",
               cmd_ready, n_start, s0 + 1);
    end
    step();
    cmd_valid = 1'b0;
    if (model(32'h0000_0AB2, e)) exp_q.push_back(e);
    write_finish = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      wait_start(s0 + 2 + i, "full_order");
      finish_xfer(is_wr[i], "full_order");
    end
    wait_start(s0 + 6, "full_fifth");
    finish_xfer(1'b1, "full_fifth");
  endtask

  task automatic test_reject();
    int s0;
    int e0;
    s0 = n_start;
    e0 = n_err;
    push_cmd(32'h0000_0007, 1'b1);
    push_cmd(32'h0000_0002, 1'b1);
    repeat (12) step();
    tests_run++;
    if (n_err != e0 + 2 || n_start != s0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reject: got errs=%0d starts=%0d busy=%b, required errs=%0d starts=%0d busy=0",
               n_err, n_start, busy, e0 + 2, s0);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    int d0;
    int e0;
    s0 = n_start;
    push_cmd(32'h0000_0081, 1'b1);
    wait_start(s0 + 1, "rst_mid");
    push_cmd(32'h0000_0013, 1'b0);
    push_cmd(32'h0000_0003, 1'b0);
    d0 = n_done;
    e0 = n_err;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    tests_run++;
    if ({read_ch, write_ch, sdram_index} !== 6'd0 || sd_card_bmp_read_addr !== 32'd0 ||
        busy !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got rd=%0d wr=%0d idx=%0d addr=%0d busy=%b ready=%b, required 0 0 0 0 0 1",
               read_ch, write_ch, sdram_index, sd_card_bmp_read_addr, busy, cmd_ready);
    end
    repeat (10) step();
    tests_run++;
    if (n_start != s0 + 1 || n_done != d0 || n_err != e0) begin
      tests_failed++;
      $display("FAIL rst_mid_flush: got starts=%0d dones=%0d errs=%0d, required %0d %0d %0d",
               n_start, n_done, n_err, s0 + 1, d0, e0);
    end
    push_cmd(32'h0000_00C2, 1'b1);
    wait_start(s0 + 2, "rst_mid_after");
    finish_xfer(1'b1, "rst_mid_after");
  endtask

`ifdef XFER_TIMEOUT_EN
  task automatic test_timeout();
    int s0;
    int d0;
    int e0;
    int budget;
    s0 = n_start;
    d0 = n_done;
    e0 = n_err;
    push_cmd(32'h0000_0081, 1'b1);
    wait_start(s0 + 1, "timeout");
    budget = 150;
    while (n_err == e0 && budget > 0) begin step(); budget--; end
    tests_run++;
    if (n_err != e0 + 1 || last_err - last_start != 100 || n_done != d0) begin
      tests_failed++;
      $display("FAIL timeout_err: got errs=%0d delay=%0d dones=%0d, required %0d 100 %0d",
               n_err, last_err - last_start, n_done, e0 + 1, d0);
    end
    step();
    tests_run++;
    if (write_ch !== 2'd0 || read_ch !== 2'd0) begin
      tests_failed++;
      $display("FAIL timeout_clear: got wr=%0d rd=%0d, required 0 0", write_ch, read_ch);
    end
  endtask
`endif

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_word     = 32'd0;
    read_finish  = 1'b0;
    write_finish = 1'b0;
    test_reset();
    test_cam2sdr();
    test_sd2sdr();
    test_full_queue();
    test_reject();
    test_reset_mid();
`ifdef XFER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) step();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL launches_missing: got %0d unlaunched, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
